// File: rtl/lsu_stbuf_queue.sv
`default_nettype none
// ============================================================================
// Module   : lsu_stbuf_queue
// Purpose  : LSU store buffer. Committed stores are queued in a circular
//            FIFO and drained in order to the DCCM/PIC write port. Loads in
//            dc2 look up the queue, and a per-byte forward of the youngest
//            matching DCCM store is registered into dc3.
// Ports    : clk, rst_l (async, active-low)
//            enq_*                  : store enqueue request
//            lsu_stbuf_commit_any   : write port accepted the head entry
//            ld_valid_dc2/ld_addr_dc2 : load forwarding lookup
//            stbuf_*_any            : head entry presented to the write port
//            stbuf_full/empty       : occupancy flags
//            stbuf_fwddata/fwdbyteen_dc3 : registered forward result
//            stbuf_overflow         : sticky, an enqueue was dropped
// Revision : 1.0 - initial release
// ============================================================================
module lsu_stbuf_queue #(
    parameter int STBUF_DEPTH = 4,
    parameter int ADDR_BITS   = 16
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 enq_valid,
    input  logic [ADDR_BITS-1:0] enq_addr,
    input  logic [31:0]          enq_data,
    input  logic [3:0]           enq_byteen,
    input  logic                 enq_in_pic,
    input  logic                 lsu_stbuf_commit_any,
    input  logic                 ld_valid_dc2,
    input  logic [ADDR_BITS-1:0] ld_addr_dc2,
    output logic                 stbuf_reqvld_any,
    output logic [ADDR_BITS-1:0] stbuf_addr_any,
    output logic [31:0]          stbuf_data_any,
    output logic [3:0]           stbuf_byteen_any,
    output logic                 stbuf_addr_in_pic_any,
    output logic                 stbuf_full,
    output logic                 stbuf_empty,
    output logic [31:0]          stbuf_fwddata_dc3,
    output logic [3:0]           stbuf_fwdbyteen_dc3,
    output logic                 stbuf_overflow
);

    localparam int C_PTR_W = $clog2(STBUF_DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;
    localparam logic [C_CNT_W-1:0] C_DEPTH    = C_CNT_W'(STBUF_DEPTH);
    localparam logic [C_PTR_W-1:0] C_LAST_PTR = C_PTR_W'(STBUF_DEPTH - 1);

    // Entry storage; the address keeps only the word-address bits.
    logic                 r_vld    [STBUF_DEPTH];
    logic [ADDR_BITS-3:0] r_addr   [STBUF_DEPTH];
    logic [31:0]          r_data   [STBUF_DEPTH];
    logic [3:0]           r_byteen [STBUF_DEPTH];
    logic                 r_pic    [STBUF_DEPTH];

    logic [C_PTR_W-1:0]   r_wr_ptr;
    logic [C_PTR_W-1:0]   r_rd_ptr;
    logic [C_CNT_W-1:0]   r_count;
    logic                 r_overflow;
    logic [31:0]          r_fwd_data;
    logic [3:0]           r_fwd_be;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_drop;
    logic [31:0]          w_fwd_data;
    logic [3:0]           w_fwd_be;
    logic                 w_unused_addr_lsbs;

    // Byte offsets of word addresses carry no information here.
    assign w_unused_addr_lsbs = ^{enq_addr[1:0], ld_addr_dc2[1:0]};

    function automatic logic [C_PTR_W-1:0] f_ptr_inc(input logic [C_PTR_W-1:0] p);
        return (p == C_LAST_PTR) ? '0 : p + C_PTR_W'(1);
    endfunction

    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);
    // A full buffer still accepts when the head is leaving in the same cycle.
    assign w_pop   = lsu_stbuf_commit_any & ~w_empty;
    assign w_push  = enq_valid & (~w_full | lsu_stbuf_commit_any);
    assign w_drop  = enq_valid & w_full & ~lsu_stbuf_commit_any;

    // ------------------------------------------------------------------
    // Entry array. Pop clears first so a same-slot push (full + commit)
    // leaves the slot valid with the new store.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < STBUF_DEPTH; i++) begin
                r_vld[i]    <= 1'b0;
                r_addr[i]   <= '0;
                r_data[i]   <= '0;
                r_byteen[i] <= '0;
                r_pic[i]    <= 1'b0;
            end
        end else begin
            for (int i = 0; i < STBUF_DEPTH; i++) begin
                if (w_pop && (r_rd_ptr == C_PTR_W'(i))) begin
                    r_vld[i] <= 1'b0;
                end
                if (w_push && (r_wr_ptr == C_PTR_W'(i))) begin
                    r_vld[i]    <= 1'b1;
                    r_addr[i]   <= enq_addr[ADDR_BITS-1:2];
                    r_data[i]   <= enq_data;
                    r_byteen[i] <= enq_byteen;
                    r_pic[i]    <= enq_in_pic;
                end
            end
        end
    end

    // Pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_W'(1);
                2'b01:   r_count <= r_count - C_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding lookup over current state: walks from oldest (read
    // pointer) to youngest so later matches override earlier ones. The
    // head being popped this cycle is still valid here; the store being
    // enqueued this cycle is not yet written and so is excluded. Loads
    // are DCCM accesses, so PIC entries never match.
    // ------------------------------------------------------------------
    always_comb begin
        logic [C_PTR_W-1:0] v_idx;
        v_idx      = '0;
        w_fwd_data = '0;
        w_fwd_be   = '0;
        for (int k = 0; k < STBUF_DEPTH; k++) begin
            v_idx = r_rd_ptr + C_PTR_W'(k);
            if (ld_valid_dc2 && r_vld[v_idx] && !r_pic[v_idx] &&
                (r_addr[v_idx] == ld_addr_dc2[ADDR_BITS-1:2])) begin
                for (int b = 0; b < 4; b++) begin
                    if (r_byteen[v_idx][b]) begin
                        w_fwd_be[b]          = 1'b1;
                        w_fwd_data[8*b +: 8] = r_data[v_idx][8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_fwd_data <= '0;
            r_fwd_be   <= '0;
        end else begin
            r_fwd_data <= w_fwd_data;
            r_fwd_be   <= w_fwd_be;
        end
    end

    // Head fields are zeroed while empty so stale popped data never shows.
    assign stbuf_reqvld_any      = ~w_empty;
    assign stbuf_addr_any        = w_empty ? '0 : {r_addr[r_rd_ptr], 2'b00};
    assign stbuf_data_any        = w_empty ? '0 : r_data[r_rd_ptr];
    assign stbuf_byteen_any      = w_empty ? '0 : r_byteen[r_rd_ptr];
    assign stbuf_addr_in_pic_any = ~w_empty & r_pic[r_rd_ptr];
    assign stbuf_full            = w_full;
    assign stbuf_empty           = w_empty;
    assign stbuf_fwddata_dc3     = r_fwd_data;
    assign stbuf_fwdbyteen_dc3   = r_fwd_be;
    assign stbuf_overflow        = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_lsu_stbuf_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_stbuf_queue
// Purpose  : Directed self-checking bench for lsu_stbuf_queue (defaults:
//            4 entries, 16-bit address).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_stbuf_queue;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        enq_valid;
    logic [15:0] enq_addr;
    logic [31:0] enq_data;
    logic [3:0]  enq_byteen;
    logic        enq_in_pic;
    logic        lsu_stbuf_commit_any;
    logic        ld_valid_dc2;
    logic [15:0] ld_addr_dc2;
    logic        stbuf_reqvld_any;
    logic [15:0] stbuf_addr_any;
    logic [31:0] stbuf_data_any;
    logic [3:0]  stbuf_byteen_any;
    logic        stbuf_addr_in_pic_any;
    logic        stbuf_full;
    logic        stbuf_empty;
    logic [31:0] stbuf_fwddata_dc3;
    logic [3:0]  stbuf_fwdbyteen_dc3;
    logic        stbuf_overflow;

    int n_checks = 0;
    int n_errors = 0;

    lsu_stbuf_queue #(.STBUF_DEPTH(4), .ADDR_BITS(16)) dut (
        .clk                   (clk),
        .rst_l                 (rst_l),
        .enq_valid             (enq_valid),
        .enq_addr              (enq_addr),
        .enq_data              (enq_data),
        .enq_byteen            (enq_byteen),
        .enq_in_pic            (enq_in_pic),
        .lsu_stbuf_commit_any  (lsu_stbuf_commit_any),
        .ld_valid_dc2          (ld_valid_dc2),
        .ld_addr_dc2           (ld_addr_dc2),
        .stbuf_reqvld_any      (stbuf_reqvld_any),
        .stbuf_addr_any        (stbuf_addr_any),
        .stbuf_data_any        (stbuf_data_any),
        .stbuf_byteen_any      (stbuf_byteen_any),
        .stbuf_addr_in_pic_any (stbuf_addr_in_pic_any),
        .stbuf_full            (stbuf_full),
        .stbuf_empty           (stbuf_empty),
        .stbuf_fwddata_dc3     (stbuf_fwddata_dc3),
        .stbuf_fwdbyteen_dc3   (stbuf_fwdbyteen_dc3),
        .stbuf_overflow        (stbuf_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        enq_valid            = 1'b0;
        enq_addr             = '0;
        enq_data             = '0;
        enq_byteen           = '0;
        enq_in_pic           = 1'b0;
        lsu_stbuf_commit_any = 1'b0;
        ld_valid_dc2         = 1'b0;
        ld_addr_dc2          = '0;
    endtask

    task automatic drive(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be,
                         input logic pic, input logic cm);
        enq_valid            = 1'b1;
        enq_addr             = a;
        enq_data             = d;
        enq_byteen           = be;
        enq_in_pic           = pic;
        lsu_stbuf_commit_any = cm;
    endtask

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic commit_one();
        lsu_stbuf_commit_any = 1'b1;
        tick();
        lsu_stbuf_commit_any = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_l = 1'b0;
        idle();
        repeat (2) tick();

        // Reset state
        chk1 ("rst_empty",  stbuf_empty, 1'b1);
        chk1 ("rst_full",   stbuf_full, 1'b0);
        chk1 ("rst_reqvld", stbuf_reqvld_any, 1'b0);
        chk16("rst_addr",   stbuf_addr_any, 16'h0000);
        chk32("rst_data",   stbuf_data_any, 32'h0);
        chk4 ("rst_byteen", stbuf_byteen_any, 4'h0);
        chk1 ("rst_pic",    stbuf_addr_in_pic_any, 1'b0);
        chk1 ("rst_ovf",    stbuf_overflow, 1'b0);
        chk4 ("rst_fwdbe",  stbuf_fwdbyteen_dc3, 4'h0);
        chk32("rst_fwdd",   stbuf_fwddata_dc3, 32'h0);
        rst_l = 1'b1;
        tick();

        // Single enqueue, head held until commit
        drive(16'h0010, 32'hAABBCCDD, 4'hF, 1'b0, 1'b0);
        tick();
        idle();
        chk1 ("enq_reqvld", stbuf_reqvld_any, 1'b1);
        chk16("enq_addr",   stbuf_addr_any, 16'h0010);
        chk32("enq_data",   stbuf_data_any, 32'hAABBCCDD);
        chk4 ("enq_byteen", stbuf_byteen_any, 4'hF);
        chk1 ("enq_empty",  stbuf_empty, 1'b0);
        repeat (3) tick();
        chk1 ("hold_reqvld", stbuf_reqvld_any, 1'b1);
        chk32("hold_data",   stbuf_data_any, 32'hAABBCCDD);
        commit_one();
        chk1 ("pop_empty",  stbuf_empty, 1'b1);
        chk1 ("pop_reqvld", stbuf_reqvld_any, 1'b0);

        // Fill, overflow drop, then full + commit accept
        for (int k = 0; k < 4; k++) begin
            drive(16'h0040 + 16'(4 * k), 32'(k + 1), 4'hF, 1'b0, 1'b0);
            tick();
        end
        idle();
        chk1 ("fill_full", stbuf_full, 1'b1);
        chk1 ("fill_ovf",  stbuf_overflow, 1'b0);
        drive(16'h0050, 32'h5, 4'hF, 1'b0, 1'b0);
        tick();
        idle();
        chk1 ("drop_full", stbuf_full, 1'b1);
        chk1 ("drop_ovf",  stbuf_overflow, 1'b1);
        chk16("drop_head", stbuf_addr_any, 16'h0040);
        chk32("drop_data", stbuf_data_any, 32'h1);
        tick();
        chk1 ("ovf_sticky", stbuf_overflow, 1'b1);
        drive(16'h0050, 32'h5, 4'hF, 1'b0, 1'b1);
        tick();
        idle();
        chk1 ("fullcm_full", stbuf_full, 1'b1);
        chk32("fullcm_head", stbuf_data_any, 32'h2);
        chk1 ("fullcm_ovf",  stbuf_overflow, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk32("drain_order", stbuf_data_any, 32'(k + 2));
            commit_one();
        end
        chk1 ("drain_empty", stbuf_empty, 1'b1);
        chk1 ("drain_full",  stbuf_full, 1'b0);

        // Forwarding: youngest byte wins, same-cycle enqueue excluded
        drive(16'h0020, 32'h11223344, 4'hF, 1'b0, 1'b0);
        tick();
        drive(16'h0020, 32'h00005500, 4'b0010, 1'b0, 1'b0);
        tick();
        drive(16'h0020, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b0);
        ld_valid_dc2 = 1'b1;
        ld_addr_dc2  = 16'h0022;
        tick();
        idle();
        chk4 ("fwd_be",   stbuf_fwdbyteen_dc3, 4'hF);
        chk32("fwd_data", stbuf_fwddata_dc3, 32'h11225544);
        ld_valid_dc2 = 1'b1;
        ld_addr_dc2  = 16'h0070;
        tick();
        idle();
        chk4 ("nomatch_be",   stbuf_fwdbyteen_dc3, 4'h0);
        chk32("nomatch_data", stbuf_fwddata_dc3, 32'h0);
        ld_valid_dc2 = 1'b1;
        ld_addr_dc2  = 16'h0020;
        tick();
        idle();
        chk32("fwd_young", stbuf_fwddata_dc3, 32'hFFFFFFFF);
        tick();
        chk4 ("noload_be", stbuf_fwdbyteen_dc3, 4'h0);
        chk32("drainA", stbuf_data_any, 32'h11223344);
        commit_one();
        chk32("drainB", stbuf_data_any, 32'h00005500);
        commit_one();
        chk32("drainC", stbuf_data_any, 32'hFFFFFFFF);
        commit_one();

        // Entry popped in the same cycle is still forwarded
        drive(16'h0060, 32'hDEADBEEF, 4'b1001, 1'b0, 1'b0);
        tick();
        idle();
        ld_valid_dc2         = 1'b1;
        ld_addr_dc2          = 16'h0060;
        lsu_stbuf_commit_any = 1'b1;
        tick();
        idle();
        chk4 ("popfwd_be",   stbuf_fwdbyteen_dc3, 4'b1001);
        chk32("popfwd_data", stbuf_fwddata_dc3, 32'hDE0000EF);
        chk1 ("popfwd_empty", stbuf_empty, 1'b1);

        // PIC entry: presented at head, never forwarded to a load
        drive(16'h0030, 32'h12345678, 4'hF, 1'b1, 1'b0);
        tick();
        idle();
        chk1 ("pic_head", stbuf_addr_in_pic_any, 1'b1);
        chk16("pic_addr", stbuf_addr_any, 16'h0030);
        ld_valid_dc2 = 1'b1;
        ld_addr_dc2  = 16'h0030;
        tick();
        idle();
        chk4 ("pic_fwdbe",   stbuf_fwdbyteen_dc3, 4'h0);
        chk32("pic_fwddata", stbuf_fwddata_dc3, 32'h0);
        commit_one();
        chk1 ("pic_empty", stbuf_empty, 1'b1);
        chk1 ("pic_clear", stbuf_addr_in_pic_any, 1'b0);

        // Pointer wrap: 3 resident, 8 enqueue/commit pairs, then drain
        for (int k = 0; k < 3; k++) begin
            drive(16'h0080 + 16'(4 * k), 32'h100 + 32'(k), 4'hF, 1'b0, 1'b0);
            tick();
        end
        for (int k = 3; k < 11; k++) begin
            chk32("wrap_head", stbuf_data_any, 32'h100 + 32'(k - 3));
            drive(16'h0080 + 16'(4 * k), 32'h100 + 32'(k), 4'hF, 1'b0, 1'b1);
            tick();
            chk1("wrap_full",  stbuf_full, 1'b0);
            chk1("wrap_empty", stbuf_empty, 1'b0);
        end
        idle();
        for (int k = 8; k < 11; k++) begin
            chk32("wrap_drain", stbuf_data_any, 32'h100 + 32'(k));
            commit_one();
        end
        chk1("wrap_done", stbuf_empty, 1'b1);

        // Mid-operation asynchronous reset
        for (int k = 0; k < 3; k++) begin
            drive(16'h00A0, 32'hC0DE0000 + 32'(k), 4'hF, 1'b0, 1'b0);
            tick();
        end
        idle();
        ld_valid_dc2 = 1'b1;
        ld_addr_dc2  = 16'h00A0;
        tick();
        idle();
        chk4("prerst_fwdbe", stbuf_fwdbyteen_dc3, 4'hF);
        #2;
        rst_l = 1'b0;
        #1;
        chk1 ("arst_reqvld", stbuf_reqvld_any, 1'b0);
        chk1 ("arst_empty",  stbuf_empty, 1'b1);
        chk32("arst_data",   stbuf_data_any, 32'h0);
        chk16("arst_addr",   stbuf_addr_any, 16'h0000);
        chk1 ("arst_ovf",    stbuf_overflow, 1'b0);
        chk4 ("arst_fwdbe",  stbuf_fwdbyteen_dc3, 4'h0);
        chk32("arst_fwdd",   stbuf_fwddata_dc3, 32'h0);
        tick();
        rst_l = 1'b1;
        tick();
        commit_one();
        chk1 ("postrst_empty",  stbuf_empty, 1'b1);
        chk1 ("postrst_reqvld", stbuf_reqvld_any, 1'b0);
        chk1 ("postrst_full",   stbuf_full, 1'b0);
        drive(16'h00B0, 32'h0BADF00D, 4'hF, 1'b0, 1'b0);
        tick();
        idle();
        chk1 ("postrst_enq", stbuf_reqvld_any, 1'b1);
        chk32("postrst_data", stbuf_data_any, 32'h0BADF00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
